// File: rtl/xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xbar_pkg
// Brief    : Shared types and sizing helpers for the Benes crossbar
//            permutation front end.
// Revision : 1.0 - initial release
// ============================================================================
package xbar_pkg;

    // Default crossbar geometry: 32 ports, 4 indices per input beat.
    localparam int c_def_size  = 32;
    localparam int c_def_lanes = 4;

    // Loader fill FSM: collecting beats, or holding a checked permutation
    // until the active slot is free.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } fill_state_t;

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xbar_perm_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : xbar_perm_loader_if
// Brief    : Beat stream carrying destination indices into the permutation
//            loader (valid/ready handshake).
// Revision : 1.0 - initial release
// ============================================================================
interface xbar_perm_loader_if
    import xbar_pkg::*;
#(
    parameter int LANES    = c_def_lanes,
    parameter int TAGWIDTH = $clog2(c_def_size)
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*TAGWIDTH-1:0] in_idx;

    modport master (
        output in_valid,
        output in_idx,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_idx,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/xbar_dup_check.sv
`default_nettype none
// ============================================================================
// Module   : xbar_dup_check
// Brief    : Combinational test-and-set of one beat of indices against the
//            running "seen" mask. Flags repeats against earlier beats and
//            between lanes of the same beat.
// Revision : 1.0 - initial release
// ============================================================================
module xbar_dup_check
    import xbar_pkg::*;
#(
    parameter  int SIZE     = c_def_size,
    parameter  int LANES    = c_def_lanes,
    localparam int TAGWIDTH = $clog2(SIZE)
) (
    input  wire logic [LANES*TAGWIDTH-1:0] i_idx,
    input  wire logic [SIZE-1:0]           i_seen,
    output logic                           o_dup,
    output logic [SIZE-1:0]                o_seen
);

    logic [SIZE-1:0] w_acc;
    logic            w_dup;

    // Walk the lanes in order so a later lane sees bits set by earlier ones.
    always_comb begin
        w_acc = i_seen;
        w_dup = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (w_acc[i_idx[k*TAGWIDTH +: TAGWIDTH]]) begin
                w_dup = 1'b1;
            end
            w_acc[i_idx[k*TAGWIDTH +: TAGWIDTH]] = 1'b1;
        end
    end

    assign o_dup  = w_dup;
    assign o_seen = w_acc;

endmodule
`default_nettype wire

// File: rtl/xbar_perm_loader.sv
`default_nettype none
// ============================================================================
// Module   : xbar_perm_loader
// Brief    : Collects a destination permutation in LANES-wide beats, rejects
//            any with a repeated index, and double-buffers good ones into a
//            stable perm vector for the control-bit generator.
// Revision : 1.0 - initial release
// ============================================================================
module xbar_perm_loader
    import xbar_pkg::*;
#(
    parameter  int SIZE     = c_def_size,
    parameter  int LANES    = c_def_lanes,
    localparam int TAGWIDTH = $clog2(SIZE),
    localparam int BEATS    = SIZE / LANES,
    localparam int BCW      = cnt_width(BEATS)
) (
    input  wire logic          clk,
    input  wire logic          n_rst,
    xbar_perm_loader_if.slave  in_if,
    output logic [TAGWIDTH-1:0] perm [SIZE],
    output logic               perm_valid,
    input  wire logic          perm_release,
    output logic               err_dup,
    output logic [BCW-1:0]     beat_cnt
);

    localparam logic [BCW-1:0] c_last_beat = BCW'(BEATS - 1);

    fill_state_t         r_state;
    logic                r_in_ready;
    logic [BCW-1:0]      r_beat_cnt;
    logic [SIZE-1:0]     r_seen;
    logic                r_bad;
    logic                r_err_dup;
    logic                r_perm_valid;
    logic [TAGWIDTH-1:0] r_shadow [SIZE];
    logic [TAGWIDTH-1:0] r_perm   [SIZE];

    logic                w_dup;
    logic [SIZE-1:0]     w_seen_next;
    logic                w_last;
    logic                w_xfer;
    logic [TAGWIDTH-1:0] w_wr_idx [LANES];

    xbar_dup_check #(
        .SIZE  (SIZE),
        .LANES (LANES)
    ) u_dup_check (
        .i_idx  (in_if.in_idx),
        .i_seen (r_seen),
        .o_dup  (w_dup),
        .o_seen (w_seen_next)
    );

    // Shadow slot for each lane of the current beat.
    for (genvar k = 0; k < LANES; k++) begin : g_wr_idx
        assign w_wr_idx[k] = TAGWIDTH'(int'(r_beat_cnt) * LANES + k);
    end

    assign w_last = (r_beat_cnt == c_last_beat);
    // Shadow moves to the active slot only from HOLD, and only when the
    // active slot is empty or being handed back this cycle.
    assign w_xfer = (r_state == HOLD) && (!r_perm_valid || perm_release);

    // Fill FSM, duplicate tracking and the double buffer, all registered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= FILL;
            r_in_ready   <= 1'b1;
            r_beat_cnt   <= '0;
            r_seen       <= '0;
            r_bad        <= 1'b0;
            r_err_dup    <= 1'b0;
            r_perm_valid <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                r_perm[i]   <= TAGWIDTH'(i);
                r_shadow[i] <= '0;
            end
        end else begin
            r_err_dup <= 1'b0;

            case (r_state)
                FILL: begin
                    if (in_if.in_valid) begin
                        for (int k = 0; k < LANES; k++) begin
                            r_shadow[w_wr_idx[k]] <= in_if.in_idx[k*TAGWIDTH +: TAGWIDTH];
                        end
                        if (w_last) begin
                            // Permutation complete: bookkeeping restarts either way.
                            r_beat_cnt <= '0;
                            r_seen     <= '0;
                            r_bad      <= 1'b0;
                            if (r_bad || w_dup) begin
                                r_err_dup <= 1'b1;
                            end else begin
                                r_state    <= HOLD;
                                r_in_ready <= 1'b0;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                            r_seen     <= w_seen_next;
                            r_bad      <= r_bad | w_dup;
                        end
                    end
                end
                HOLD: begin
                    if (w_xfer) begin
                        r_state    <= FILL;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= FILL;
                    r_in_ready <= 1'b1;
                end
            endcase

            // A release in the same cycle as a transfer keeps perm_valid high.
            if (w_xfer) begin
                r_perm       <= r_shadow;
                r_perm_valid <= 1'b1;
            end else if (perm_release) begin
                r_perm_valid <= 1'b0;
            end
        end
    end

    assign in_if.in_ready = r_in_ready;
    assign perm           = r_perm;
    assign perm_valid     = r_perm_valid;
    assign err_dup        = r_err_dup;
    assign beat_cnt       = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_xbar_perm_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_xbar_perm_loader
// Brief    : Scoreboard bench for xbar_perm_loader (SIZE=8, LANES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbar_perm_loader;
    import xbar_pkg::*;

    localparam int SIZE  = 8;
    localparam int LANES = 4;
    localparam int TW    = 3;
    localparam int BEATS = 2;
    localparam int PW    = SIZE * TW;
    localparam int BW    = LANES * TW;

    typedef struct packed {
        logic          is_err;
        logic [PW-1:0] p;
    } ev_t;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [TW-1:0] perm [SIZE];
    logic          perm_valid;
    logic          err_dup;
    logic [0:0]    beat_cnt;
    logic          rel_dir = 1'b0;
    logic          rel_rnd = 1'b0;
    logic          rnd_mode = 1'b0;
    logic          perm_release;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    assign perm_release = rnd_mode ? rel_rnd : rel_dir;

    always #5 clk = ~clk;

    xbar_perm_loader_if #(.LANES(LANES), .TAGWIDTH(TW)) bus ();

    xbar_perm_loader #(.SIZE(SIZE), .LANES(LANES)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .in_if        (bus),
        .perm         (perm),
        .perm_valid   (perm_valid),
        .perm_release (perm_release),
        .err_dup      (err_dup),
        .beat_cnt     (beat_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [PW-1:0] pk(input logic [TW-1:0] a [SIZE]);
        logic [PW-1:0] r;
        for (int i = 0; i < SIZE; i++) r[i*TW +: TW] = a[i];
        return r;
    endfunction

    function automatic logic [PW-1:0] mk(input int v [SIZE]);
        logic [PW-1:0] r;
        for (int i = 0; i < SIZE; i++) r[i*TW +: TW] = TW'(v[i]);
        return r;
    endfunction

    function automatic logic [PW-1:0] ident();
        int v [SIZE];
        for (int i = 0; i < SIZE; i++) v[i] = i;
        return mk(v);
    endfunction

    function automatic logic [PW-1:0] rand_perm();
        int v [SIZE];
        int j, t;
        for (int i = 0; i < SIZE; i++) v[i] = i;
        for (int i = SIZE - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = v[i]; v[i] = v[j]; v[j] = t;
        end
        return mk(v);
    endfunction

    // Reference rule: accepted only if every destination occurs exactly once.
    function automatic bit is_perm(input logic [PW-1:0] p);
        int cnt [SIZE];
        for (int i = 0; i < SIZE; i++) cnt[i] = 0;
        for (int i = 0; i < SIZE; i++) cnt[int'(p[i*TW +: TW])]++;
        for (int i = 0; i < SIZE; i++) if (cnt[i] != 1) return 0;
        return 1;
    endfunction

    // Model state: beats gathered so far of the permutation being streamed.
    logic [PW-1:0] acc;
    int            nb = 0;

    task automatic send_beat(input logic [BW-1:0] beat, input int gap);
        int t = 0;
        repeat (gap) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_idx   = BW'($urandom);
        end
        @(negedge clk);
        while (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            bus.in_idx   = BW'($urandom);
            t++;
            if (t > 200) timeout_fail("in_ready_wait");
            @(negedge clk);
        end
        chk("beat_cnt", beat_cnt, nb);
        bus.in_valid = 1'b1;
        bus.in_idx   = beat;
        acc[nb*BW +: BW] = beat;
        nb++;
        if (nb == BEATS) begin
            exp_q.push_back(ev_t'{is_err: !is_perm(acc), p: acc});
            nb = 0;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_idx   = BW'($urandom);
    endtask

    // Streams a whole permutation; returns on the negedge after the last beat
    // was accepted.
    task automatic send_perm(input logic [PW-1:0] p, input bit gaps);
        for (int b = 0; b < BEATS; b++)
            send_beat(p[b*BW +: BW], gaps ? int'($urandom_range(0, 2)) : 0);
        idle();
    endtask

    // Monitor: a transfer shows as in_ready rising; err_dup as a pulse.
    initial begin
        logic          prev_rdy;
        logic [PW-1:0] cur;
        logic [PW-1:0] pnow;
        ev_t           e;
        prev_rdy = 1'b1;
        cur      = ident();
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                prev_rdy = 1'b1;
                cur      = ident();
                continue;
            end
            pnow = pk(perm);
            if (!prev_rdy && bus.in_ready) begin
                if (exp_q.size() == 0) begin
                    chk("xfer_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_kind", e.is_err, 1'b0);
                    chk("xfer_perm", pnow, e.p);
                    chk("xfer_valid", perm_valid, 1'b1);
                end
                cur = pnow;
            end else begin
                chk("perm_stable", pnow, cur);
            end
            if (err_dup) begin
                if (exp_q.size() == 0) begin
                    chk("err_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("err_kind", e.is_err, 1'b1);
                end
            end
            prev_rdy = bus.in_ready;
        end
    end

    // Random consumer release pattern.
    initial begin
        forever begin
            @(negedge clk);
            rel_rnd = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #300000;
        timeout_fail("global_watchdog");
    end

    initial begin
        logic [PW-1:0] pa, pb, pc, p;
        int            i, j, t;
        bus.in_valid = 1'b0;
        bus.in_idx   = '0;
        acc          = '0;
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_perm", pk(perm), ident());
        chk("rst_valid", perm_valid, 1'b0);
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_err", err_dup, 1'b0);
        chk("rst_beat", beat_cnt, 1'b0);

        // Basic load and latency
        pa = mk('{3, 1, 0, 2, 7, 5, 6, 4});
        send_perm(pa, 0);
        chk("hold_ready", bus.in_ready, 1'b0);
        chk("hold_valid", perm_valid, 1'b0);
        @(negedge clk);
        chk("load_valid", perm_valid, 1'b1);
        chk("load_perm", pk(perm), pa);
        chk("load_ready", bus.in_ready, 1'b1);

        // Release with nothing queued drops perm_valid, perm kept
        rel_dir = 1'b1;
        @(negedge clk);
        rel_dir = 1'b0;
        chk("rel_valid", perm_valid, 1'b0);
        chk("rel_perm", pk(perm), pa);

        // Cross-beat duplicate
        send_perm(mk('{0, 1, 2, 3, 4, 5, 6, 2}), 0);
        chk("xdup_err", err_dup, 1'b1);
        chk("xdup_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("xdup_err_once", err_dup, 1'b0);
        chk("xdup_valid", perm_valid, 1'b0);
        chk("xdup_perm", pk(perm), pa);
        pa = rand_perm();
        send_perm(pa, 0);
        @(negedge clk);
        chk("after_err_valid", perm_valid, 1'b1);
        chk("after_err_perm", pk(perm), pa);

        // Intra-beat duplicate
        send_perm(mk('{5, 5, 0, 1, 2, 3, 4, 6}), 0);
        chk("idup_err", err_dup, 1'b1);
        @(negedge clk);
        chk("idup_err_once", err_dup, 1'b0);
        chk("idup_perm", pk(perm), pa);
        chk("idup_valid", perm_valid, 1'b1);

        // Back-pressure in HOLD, then release-and-transfer in one cycle
        pb = rand_perm();
        send_perm(pb, 0);
        repeat (3) begin
            chk("bp_ready", bus.in_ready, 1'b0);
            chk("bp_perm", pk(perm), pa);
            chk("bp_valid", perm_valid, 1'b1);
            @(negedge clk);
        end
        rel_dir = 1'b1;
        @(negedge clk);
        rel_dir = 1'b0;
        chk("swap_perm", pk(perm), pb);
        chk("swap_valid", perm_valid, 1'b1);
        chk("swap_ready", bus.in_ready, 1'b1);

        // Reset mid-fill
        pc = rand_perm();
        send_beat(pc[BW-1:0], 0);
        idle();
        chk("mid_beat", beat_cnt, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_perm", pk(perm), ident());
        chk("arst_valid", perm_valid, 1'b0);
        chk("arst_beat", beat_cnt, 1'b0);
        chk("arst_err", err_dup, 1'b0);
        chk("arst_ready", bus.in_ready, 1'b1);
        nb = 0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        #2 n_rst = 1'b1;
        pc = rand_perm();
        send_perm(pc, 0);
        @(negedge clk);
        chk("post_rst_valid", perm_valid, 1'b1);
        chk("post_rst_perm", pk(perm), pc);

        // Randomized traffic with random gaps, releases and injected repeats
        rnd_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            p = rand_perm();
            if ($urandom_range(0, 3) == 0) begin
                i = int'($urandom_range(0, SIZE - 1));
                j = (i + int'($urandom_range(1, SIZE - 1))) % SIZE;
                p[i*TW +: TW] = p[j*TW +: TW];
            end
            send_perm(p, 1);
        end
        rnd_mode = 1'b0;
        rel_dir  = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
        rel_dir = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xbar_perm_loader.md
# xbar_perm_loader

Upstream feeder for the pipelined Benes crossbar's control-bit generator. It accepts a destination permutation as a stream of `LANES` indices per beat and checks that it is a true permutation (no repeated index). Valid permutations are double-buffered, then presented as a stable `perm` vector that the control-bit generator consumes. The next permutation can stream in while the current one is in use; malformed permutations are dropped and reported.

## Interface
- `SIZE`, 32, crossbar ports; power of two, ≥ 2
- `LANES`, 4, indices per input beat; power of two, divides `SIZE`
- `TAGWIDTH`, `$clog2(SIZE)` (localparam), index width
- `BEATS`, `SIZE/LANES` (localparam), beats per permutation
- `clk`  in  1  clock
- `n_rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  beat valid
- `in_ready`  out  1  loader can accept a beat
- `in_idx`  in  `LANES*TAGWIDTH`  lane k (bits `[k*TAGWIDTH +: TAGWIDTH]`) = destination of input port `beat*LANES+k`
- `perm`  out  `[SIZE-1:0][TAGWIDTH]` unpacked  active permutation, to the control-bit generator
- `perm_valid`  out  1  `perm` holds a checked permutation
- `perm_release`  in  1  consumer is finished with the active permutation
- `err_dup`  out  1  one-cycle pulse: the permutation just completed had a duplicate and was discarded
- `beat_cnt`  out  `$clog2(BEATS)` (min 1)  index of the next beat expected

## Operation
- Fill FSM states: FILL, HOLD.
- FILL: `in_ready`=1. On handshake, write the lanes into shadow entries `beat_cnt*LANES+k`.
  - For each lane index, test and set bit `idx` of the `SIZE`-bit `seen` mask.
  - A duplicate against `seen`, or between lanes of the same beat, sets sticky `bad`.
  - Increment `beat_cnt`.
- Last beat (`beat_cnt==BEATS-1`) handshake:
  - `beat_cnt`→0.
  - `seen` cleared.
  - If `bad` or duplicate in this beat: pulse `err_dup` next cycle, clear `bad`, stay in FILL; shadow is discarded.
  - Otherwise go to HOLD.
- HOLD: `in_ready`=0. Transfer shadow→active when `!perm_valid || perm_release`. On transfer, `perm_valid`←1 and the state returns to FILL.
- `perm_release` with no transfer in that cycle: `perm_valid`←0; `perm` keeps its last value.
- `perm_release` while `perm_valid`=0: ignored.
- `perm` changes only on a transfer.

## Timing
- Reset values:
  - `perm[i]=i` (identity).
  - `perm_valid`=0.
  - `err_dup`=0.
  - `beat_cnt`=0.
  - State FILL, so `in_ready`=1 one cycle after reset deassertion.
  - `seen`=0, `bad`=0.
- Latency: last good beat accepted at cycle t → HOLD at t+1 → `perm_valid`/new `perm` visible at t+2 if the active slot is free or released at t+1.
- Throughput: `BEATS`+1 cycles per permutation (one HOLD bubble) when the consumer releases promptly.
- Release and transfer in the same HOLD cycle: new `perm` loads and `perm_valid` stays 1, with no gap.
- `err_dup` is asserted the cycle after the offending last beat, for exactly one cycle.
- `in_valid` without `in_ready`: no state change. Data need not be held stable; the handshake is registered-accept only.
- Reset mid-fill or in HOLD: all state is lost and outputs return to reset values asynchronously. A partial permutation is never presented.
- No combinational path from `in_valid`/`in_idx` to `in_ready`. `in_ready` depends on state only.

## Structure
- `xbar_pkg`: add `fill_state_t` (FILL, HOLD). Reuse the package's existing `SIZE`/`TAGWIDTH` conventions.
- One sub-module, `xbar_dup_check`: combinational; takes `LANES` indices plus `seen` and returns `dup` and the updated `seen`.
- The active buffer output connects directly to the control-bit generator's `perm` port.

## Test plan
All scenarios use `SIZE`=8, `LANES`=4.
- Reset → `perm`={0..7}, `perm_valid`=0, `in_ready`=1, `err_dup`=0.
- Beats {3,1,0,2}, {7,5,6,4} on consecutive cycles → `perm_valid`=1 two cycles after the 2nd beat, `perm`={3,1,0,2,7,5,6,4}.
- Beats {0,1,2,3}, {4,5,6,2} → `err_dup` pulses once, `perm_valid` stays 0, `perm` unchanged. A following valid permutation then loads normally.
- Intra-beat duplicate {5,5,0,1}, then {2,3,4,6} → `err_dup` after the 2nd beat; the permutation is discarded.
- Perm A active with no release, perm B streamed → loader sits in HOLD with `in_ready`=0. `perm_release` pulse → `perm`=B the next cycle, `perm_valid` stays 1, `in_ready`=1.
- Assert `n_rst`=0 after one beat of a permutation → immediate identity/0 outputs. A full valid permutation streamed after reset loads correctly with `beat_cnt` restarting at 0.
